stmm_mc: RTL and testbench

Multi-lane, integer-requantising successor to the single-lane streaming matrix-vector unit. It computes Y = requant(W·X) for a rows×N int8 weight matrix against one int8 vector X. LANES output rows are processed per weight fetch, with chunked MAC, a per-call fixed-point scale, an optional ReLU mode and an abort. The block sits in the exec unit between the weight BRAM (read port) and the activation register file.

---
 rtl/stmm_pkg.sv | 39 +++
 rtl/stmm_mc_if.sv | 46 ++++
 rtl/stmm_requant.sv | 60 ++++++
 rtl/stmm_mc.sv | 226 ++++++++++++++++++++++
 tb/tb_stmm_mc.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/stmm_pkg.sv
// Shared definitions for the stmm_mc multi-lane matrix-vector unit.
//   state_t   : control FSM states
//   ZP_W      : width of the signed zero-point inputs
//   acc_width : accumulator width that cannot overflow for an N-element dot product
//   idx_width : counter/address width for a range 0..n-1 (minimum 1 bit)
//   sat_q     : clamp a wide signed value into the signed q-bit range
package stmm_pkg;

  localparam int ZP_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_MAC,
    S_RQ1,
    S_RQ2
  } state_t;

  // Each widened product is at most 2*(q+1) bits; summing n of them adds clog2(n).
  function automatic int acc_width(input int n, input int q);
    return 2 * (q + 1) + $clog2(n);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic signed [63:0] sat_q(input logic signed [63:0] v, input int q);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (q - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (q - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/stmm_mc_if.sv
// Bus bundle between the exec unit / weight BRAM and stmm_mc.
//   master : exec side (drives job controls, config, X_in and the BRAM read data W_data)
//   slave  : stmm_mc (drives W_rd/W_addr, Y_out and the status flags)
// Signals: start, abort, X_in, rows, relu_en, scale_m, scale_sh, z_X, z_W, z_Y,
//          W_rd, W_addr, W_data, Y_out, busy, out_valid, done.
interface stmm_mc_if import stmm_pkg::*; #(
  parameter int N     = 176,
  parameter int P     = 704,
  parameter int LANES = 4,
  parameter int Q     = 8,
  parameter int M_W   = 16,
  parameter int SH_W  = 5
) ();

  localparam int RW = $clog2(P + 1);
  localparam int AW = idx_width(P / LANES);

  logic                   start;
  logic                   abort;
  logic [Q*N-1:0]         X_in;
  logic [RW-1:0]          rows;
  logic                   relu_en;
  logic [M_W-1:0]         scale_m;
  logic [SH_W-1:0]        scale_sh;
  logic signed [ZP_W-1:0] z_X;
  logic signed [ZP_W-1:0] z_W;
  logic signed [ZP_W-1:0] z_Y;
  logic                   W_rd;
  logic [AW-1:0]          W_addr;
  logic [LANES*Q*N-1:0]   W_data;
  logic [Q*P-1:0]         Y_out;
  logic                   busy;
  logic                   out_valid;
  logic                   done;

  modport master (
    output start, abort, X_in, rows, relu_en, scale_m, scale_sh, z_X, z_W, z_Y, W_data,
    input  W_rd, W_addr, Y_out, busy, out_valid, done
  );

  modport slave (
    input  start, abort, X_in, rows, relu_en, scale_m, scale_sh, z_X, z_W, z_Y, W_data,
    output W_rd, W_addr, Y_out, busy, out_valid, done
  );

endinterface

// File: rtl/stmm_requant.sv
// Per-lane requantiser: scales a finished dot-product accumulator back to Q bits.
//   p1 (RQ1): r_prod_p1 = acc * scale_m, registered when i_en_p1 is high
//   p2 (RQ2): round-half-up arithmetic shift, add z_Y, optional ReLU at z_Y,
//             saturate; o_y is combinational from r_prod_p1 and is consumed
//             by the parent in the cycle after i_en_p1.
// Ports: clk, i_acc, i_scale_m, i_scale_sh, i_z_y, i_relu_en, i_en_p1, o_y.
module stmm_requant import stmm_pkg::*; #(
  parameter int ACC_W = 26,
  parameter int M_W   = 16,
  parameter int SH_W  = 5,
  parameter int Q     = 8
) (
  input  logic                   clk,
  input  logic signed [ACC_W-1:0] i_acc,
  input  logic [M_W-1:0]         i_scale_m,
  input  logic [SH_W-1:0]        i_scale_sh,
  input  logic signed [ZP_W-1:0] i_z_y,
  input  logic                   i_relu_en,
  input  logic                   i_en_p1,
  output logic signed [Q-1:0]    o_y
);

  localparam int P_W = ACC_W + M_W + 1;
  localparam int R_W = P_W + 1;
  localparam int Y_W = R_W + 1;

  logic signed [P_W-1:0] r_prod_p1;
  logic signed [R_W-1:0] w_rnd_p2;
  logic signed [Y_W-1:0] w_zy_p2;
  logic signed [Y_W-1:0] w_y_p2;
  logic signed [63:0]    w_sat_p2;

  // Adding half an LSB before the arithmetic shift gives round-half-up
  // (ties go towards +inf for both signs).
  function automatic logic signed [R_W-1:0] round_shift(input logic signed [P_W-1:0] p,
                                                        input logic [SH_W-1:0]     sh);
    logic signed [R_W-1:0] ext;
    logic signed [R_W-1:0] bias;
    ext  = R_W'(p);
    bias = '0;
    if (sh != '0) bias = R_W'(1) << (sh - SH_W'(1));
    return (ext + bias) >>> sh;
  endfunction

  // ---- stage p1: scale multiply (scale_m is unsigned, so zero-extend it) ----
  always_ff @(posedge clk) begin
    if (i_en_p1) r_prod_p1 <= P_W'(i_acc) * P_W'($signed({1'b0, i_scale_m}));
  end

  // ---- stage p2: round, offset, ReLU, saturate ----
  always_comb begin
    w_rnd_p2 = round_shift(r_prod_p1, i_scale_sh);
    w_zy_p2  = Y_W'(i_z_y);
    w_y_p2   = Y_W'(w_rnd_p2) + w_zy_p2;
    if (i_relu_en && (w_y_p2 < w_zy_p2)) w_y_p2 = w_zy_p2;
    w_sat_p2 = sat_q(64'(w_y_p2), Q);
    o_y      = w_sat_p2[Q-1:0];
  end

endmodule

// File: rtl/stmm_mc.sv
// stmm_mc: multi-lane requantising matrix-vector unit, Y = requant(W * X).
// LANES rows are fetched together as one row group; each group runs
// FETCH -> WAIT (W_LAT) -> MAC (N/CH) -> RQ1 -> RQ2, and RQ2 writes the
// group's in-range rows into the Y register bank.
// Ports: clk, rst (synchronous, active-high), bus (stmm_mc_if.slave):
//   start/abort job control, X_in/rows/relu_en/scale_m/scale_sh/z_* sampled
//   on accepted start, W_rd/W_addr/W_data weight read port, Y_out result bank,
//   busy/out_valid/done status.
module stmm_mc import stmm_pkg::*; #(
  parameter int N     = 176,
  parameter int P     = 704,
  parameter int LANES = 4,
  parameter int CH    = 16,
  parameter int Q     = 8,
  parameter int M_W   = 16,
  parameter int SH_W  = 5,
  parameter int W_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  stmm_mc_if.slave bus
);

  localparam int ACC_W = acc_width(N, Q);
  localparam int RW    = $clog2(P + 1);
  localparam int AW    = idx_width(P / LANES);
  localparam int NCH   = N / CH;
  localparam int CW    = idx_width(NCH);
  localparam int WW    = idx_width(W_LAT);
  localparam int TW    = 2 * (Q + 1);

  state_t                 r_state;
  logic [AW-1:0]          r_g;
  logic [AW-1:0]          r_glast;
  logic [RW-1:0]          r_rows;
  logic [WW-1:0]          r_wcnt;
  logic [CW-1:0]          r_c;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_out_valid;
  logic                   r_w_rd;
  logic [AW-1:0]          r_w_addr;

  logic [Q*N-1:0]         r_x;
  logic                   r_relu;
  logic [M_W-1:0]         r_m;
  logic [SH_W-1:0]        r_sh;
  logic signed [ZP_W-1:0] r_zx;
  logic signed [ZP_W-1:0] r_zw;
  logic signed [ZP_W-1:0] r_zy;
  logic [LANES*Q*N-1:0]   r_w;
  logic signed [ACC_W-1:0] r_acc [LANES];
  logic [Q*P-1:0]         r_y;

  logic [RW-1:0]          w_rows_cl;
  logic [AW-1:0]          w_glast;
  logic                   w_accept;
  logic                   w_wait_last;
  logic signed [ACC_W-1:0] w_chunk [LANES];
  logic signed [Q-1:0]    w_res [LANES];

  // Zero-point subtraction is done at Q+1 bits so that e.g. -128 - 127 cannot wrap.
  function automatic logic signed [TW-1:0] mac_term(input logic [Q-1:0]         x,
                                                    input logic [Q-1:0]         w,
                                                    input logic signed [ZP_W-1:0] zx,
                                                    input logic signed [ZP_W-1:0] zw);
    logic signed [Q:0] xd;
    logic signed [Q:0] wd;
    xd = (Q + 1)'($signed(x)) - (Q + 1)'(zx);
    wd = (Q + 1)'($signed(w)) - (Q + 1)'(zw);
    return TW'(xd) * TW'(wd);
  endfunction

  always_comb begin
    w_rows_cl   = (bus.rows > RW'(P)) ? RW'(P) : bus.rows;
    // Last group index G-1; meaningless (and unused) when rows == 0.
    w_glast     = AW'((int'(w_rows_cl) + LANES - 1) / LANES - 1);
    w_accept    = (r_state == S_IDLE) && bus.start && !bus.abort;
    w_wait_last = (r_state == S_WAIT) && (r_wcnt == WW'(W_LAT - 1));
  end

  // Control FSM; abort from any non-idle state wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_g         <= '0;
      r_glast     <= '0;
      r_rows      <= '0;
      r_wcnt      <= '0;
      r_c         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_w_rd      <= 1'b0;
      r_w_addr    <= '0;
    end else begin
      r_done <= 1'b0;
      r_w_rd <= 1'b0;
      if (bus.abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_out_valid <= 1'b0;
              r_rows      <= w_rows_cl;
              r_glast     <= w_glast;
              r_g         <= '0;
              if (w_rows_cl == '0) begin
                r_done      <= 1'b1;
                r_out_valid <= 1'b1;
              end else begin
                r_busy   <= 1'b1;
                r_state  <= S_FETCH;
                r_w_rd   <= 1'b1;
                r_w_addr <= '0;
              end
            end
          end
          S_FETCH: begin
            r_wcnt  <= '0;
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (w_wait_last) begin
              r_c     <= '0;
              r_state <= S_MAC;
            end else begin
              r_wcnt <= r_wcnt + WW'(1);
            end
          end
          S_MAC: begin
            if (r_c == CW'(NCH - 1)) r_state <= S_RQ1;
            else                     r_c     <= r_c + CW'(1);
          end
          S_RQ1: r_state <= S_RQ2;
          S_RQ2: begin
            if (r_g == r_glast) begin
              r_state     <= S_IDLE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_out_valid <= 1'b1;
            end else begin
              r_g      <= r_g + AW'(1);
              r_w_addr <= r_g + AW'(1);
              r_w_rd   <= 1'b1;
              r_state  <= S_FETCH;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Chunk partial sum per lane for the chunk selected by r_c.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_chunk[l] = '0;
      for (int j = 0; j < CH; j++) begin
        w_chunk[l] = w_chunk[l] + ACC_W'(mac_term(
                       r_x[(int'(r_c) * CH + j) * Q +: Q],
                       r_w[l * Q * N + (int'(r_c) * CH + j) * Q +: Q],
                       r_zx, r_zw));
      end
    end
  end

  // ---- stage p0: job sampling, weight capture and MAC accumulation ----
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_x    <= bus.X_in;
      r_relu <= bus.relu_en;
      r_m    <= bus.scale_m;
      r_sh   <= bus.scale_sh;
      r_zx   <= bus.z_X;
      r_zw   <= bus.z_W;
      r_zy   <= bus.z_Y;
    end
    if (w_wait_last) begin
      r_w <= bus.W_data;
      for (int l = 0; l < LANES; l++) r_acc[l] <= '0;
    end else if (r_state == S_MAC) begin
      for (int l = 0; l < LANES; l++) r_acc[l] <= r_acc[l] + w_chunk[l];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    stmm_requant #(
      .ACC_W (ACC_W),
      .M_W   (M_W),
      .SH_W  (SH_W),
      .Q     (Q)
    ) u_rq (
      .clk        (clk),
      .i_acc      (r_acc[l]),
      .i_scale_m  (r_m),
      .i_scale_sh (r_sh),
      .i_z_y      (r_zy),
      .i_relu_en  (r_relu),
      .i_en_p1    (r_state == S_RQ1),
      .o_y        (w_res[l])
    );
  end

  // ---- stage p2: Y bank write; rows at or beyond r_rows keep prior contents ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y <= '0;
    end else if ((r_state == S_RQ2) && !bus.abort) begin
      for (int l = 0; l < LANES; l++) begin
        if (int'(r_g) * LANES + l < int'(r_rows))
          r_y[(int'(r_g) * LANES + l) * Q +: Q] <= w_res[l];
      end
    end
  end

  assign bus.W_rd      = r_w_rd;
  assign bus.W_addr    = r_w_addr;
  assign bus.Y_out     = r_y;
  assign bus.busy      = r_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_stmm_mc.sv
// Directed testbench for stmm_mc with N=16, P=8, LANES=4, CH=4, W_LAT=1 (T_G=8).
// Each job is started in cycle 0 and observed for a fixed window of cycles;
// expected values are hand-computed constants.
module tb_stmm_mc;

  localparam int N     = 16;
  localparam int P     = 8;
  localparam int LANES = 4;
  localparam int CH    = 4;
  localparam int Q     = 8;
  localparam int M_W   = 16;
  localparam int SH_W  = 5;
  localparam int W_LAT = 1;
  localparam int WIN   = 40;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] w_val;

  int n_chk = 0;
  int n_err = 0;
  int done_cyc;
  int done_n;
  int rd_n;
  int rd_addr [8];
  int rd_cyc  [8];
  logic busy_log [WIN+1];
  logic ov_log   [WIN+1];

  stmm_mc_if #(.N(N), .P(P), .LANES(LANES), .Q(Q), .M_W(M_W), .SH_W(SH_W)) bus ();

  stmm_mc #(
    .N(N), .P(P), .LANES(LANES), .CH(CH), .Q(Q), .M_W(M_W), .SH_W(SH_W), .W_LAT(W_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Weight BRAM model with one cycle of read latency; every element holds w_val.
  always @(posedge clk) begin
    if (bus.W_rd) bus.W_data <= {(LANES*N){w_val}};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] yfill(input logic [7:0] v);
    return {P{v}};
  endfunction

  task automatic set_cfg(input logic [7:0] x, input logic [7:0] w, input logic [15:0] m,
                         input logic [4:0] sh, input logic [7:0] zx, input logic [7:0] zw,
                         input logic [7:0] zy, input logic relu);
    bus.X_in     = {N{x}};
    w_val        = w;
    bus.scale_m  = m;
    bus.scale_sh = sh;
    bus.z_X      = zx;
    bus.z_W      = zw;
    bus.z_Y      = zy;
    bus.relu_en  = relu;
  endtask

  // Start in cycle 0, then observe cycles 1..WIN at the falling edge.
  // abort_at / restart_at / rst_at pulse the input during that cycle (-1 = never).
  task automatic run_job(input int rows_i, input int abort_at, input int restart_at,
                         input int rst_at, input bit abort0);
    done_cyc = -1;
    done_n   = 0;
    rd_n     = 0;
    @(negedge clk);
    bus.rows  = 4'(rows_i);
    bus.start = 1'b1;
    bus.abort = abort0;
    for (int c = 1; c <= WIN; c++) begin
      @(negedge clk);
      busy_log[c] = bus.busy;
      ov_log[c]   = bus.out_valid;
      if (bus.done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (bus.W_rd) begin
        if (rd_n < 8) begin
          rd_addr[rd_n] = int'(bus.W_addr);
          rd_cyc[rd_n]  = c;
        end
        rd_n++;
      end
      bus.start = (c == restart_at);
      if (c == restart_at) bus.X_in = {N{8'h05}};
      bus.abort = (c == abort_at);
      rst       = (c == rst_at);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.rows  = '0;
    set_cfg(8'h00, 8'h00, 16'd1, 5'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_Y", bus.Y_out, 64'h0);
    check("rst_busy", bus.busy, 0);
    check("rst_ov", bus.out_valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_wrd", bus.W_rd, 0);
    check("rst_waddr", bus.W_addr, 0);

    // Basic: 16 * 1 * 1 = 16 in every row, two groups.
    set_cfg(8'd1, 8'd1, 16'd1, 5'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    run_job(8, -1, -1, -1, 1'b0);
    check("basic_Y", bus.Y_out, yfill(8'h10));
    check("basic_done_cyc", done_cyc, 17);
    check("basic_done_n", done_n, 1);
    check("basic_rd_n", rd_n, 2);
    check("basic_rd_addr0", rd_addr[0], 0);
    check("basic_rd_addr1", rd_addr[1], 1);
    check("basic_rd_cyc0", rd_cyc[0], 1);
    check("basic_rd_cyc1", rd_cyc[1], 9);
    check("basic_busy_c1", busy_log[1], 1);
    check("basic_busy_c17", busy_log[17], 0);
    check("basic_ov_c2", ov_log[2], 0);
    check("basic_ov_c17", ov_log[17], 1);

    // Saturation at both ends.
    set_cfg(8'd127, 8'd127, 16'd1, 5'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    run_job(8, -1, -1, -1, 1'b0);
    check("sat_pos_Y", bus.Y_out, yfill(8'h7f));
    set_cfg(8'h80, 8'd127, 16'd1, 5'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    run_job(8, -1, -1, -1, 1'b0);
    check("sat_neg_Y", bus.Y_out, yfill(8'h80));

    // Rounding: 48/32 = 1.5 -> 2, +10 = 12; -1.5 -> -1, +10 = 9.
    set_cfg(8'd1, 8'd1, 16'd3, 5'd5, 8'h00, 8'h00, 8'd10, 1'b0);
    run_job(8, -1, -1, -1, 1'b0);
    check("round_pos_Y", bus.Y_out, yfill(8'h0c));
    set_cfg(8'hff, 8'd1, 16'd3, 5'd5, 8'h00, 8'h00, 8'd10, 1'b0);
    run_job(8, -1, -1, -1, 1'b0);
    check("round_neg_Y", bus.Y_out, yfill(8'h09));

    // Input zero points cancel the data: result is z_Y = -3.
    set_cfg(8'd1, 8'd1, 16'd1, 5'd0, 8'd1, 8'd1, 8'hfd, 1'b0);
    run_job(8, -1, -1, -1, 1'b0);
    check("zp_Y", bus.Y_out, yfill(8'hfd));

    // -16 + 5 = -11 without ReLU, clamped to z_Y = 5 with ReLU.
    set_cfg(8'hff, 8'd1, 16'd1, 5'd0, 8'h00, 8'h00, 8'd5, 1'b0);
    run_job(8, -1, -1, -1, 1'b0);
    check("relu_off_Y", bus.Y_out, yfill(8'hf5));
    set_cfg(8'hff, 8'd1, 16'd1, 5'd0, 8'h00, 8'h00, 8'd5, 1'b1);
    run_job(8, -1, -1, -1, 1'b0);
    check("relu_on_Y", bus.Y_out, yfill(8'h05));

    // Partial job: preload 16, then rows=5 with X=2 writes 32 into rows 0-4 only.
    set_cfg(8'd1, 8'd1, 16'd1, 5'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    run_job(8, -1, -1, -1, 1'b0);
    check("preload_Y", bus.Y_out, yfill(8'h10));
    set_cfg(8'd2, 8'd1, 16'd1, 5'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    run_job(5, -1, -1, -1, 1'b0);
    check("part_Y", bus.Y_out, 64'h1010102020202020);
    check("part_done_cyc", done_cyc, 17);

    // Empty job: done and out_valid in cycle 1, no reads, busy never set.
    run_job(0, -1, -1, -1, 1'b0);
    check("empty_done_cyc", done_cyc, 1);
    check("empty_done_n", done_n, 1);
    check("empty_rd_n", rd_n, 0);
    check("empty_busy_c1", busy_log[1], 0);
    check("empty_ov_c1", ov_log[1], 1);
    check("empty_Y", bus.Y_out, 64'h1010102020202020);

    // rows=9 is clamped to 8: two groups only.
    set_cfg(8'd3, 8'd1, 16'd1, 5'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    run_job(9, -1, -1, -1, 1'b0);
    check("clamp_Y", bus.Y_out, yfill(8'h30));
    check("clamp_done_cyc", done_cyc, 17);
    check("clamp_rd_n", rd_n, 2);

    // Abort in a MAC cycle of group 1 (cycle 12): group 0 rows stay written.
    set_cfg(8'd1, 8'd1, 16'd1, 5'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    run_job(8, 12, -1, -1, 1'b0);
    check("abort_busy_c12", busy_log[12], 1);
    check("abort_busy_c13", busy_log[13], 0);
    check("abort_done_n", done_n, 0);
    check("abort_rd_n", rd_n, 2);
    check("abort_ov", bus.out_valid, 0);
    check("abort_Y", bus.Y_out, 64'h3030303010101010);

    // start while busy (with X_in changed) is ignored.
    set_cfg(8'd1, 8'd1, 16'd1, 5'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    run_job(8, -1, 5, -1, 1'b0);
    check("restart_busy_c6", busy_log[6], 1);
    check("restart_done_cyc", done_cyc, 17);
    check("restart_done_n", done_n, 1);
    check("restart_rd_n", rd_n, 2);
    check("restart_Y", bus.Y_out, yfill(8'h10));

    // start and abort together in IDLE: nothing happens.
    set_cfg(8'd2, 8'd1, 16'd1, 5'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    run_job(8, -1, -1, -1, 1'b1);
    check("sa_busy_c1", busy_log[1], 0);
    check("sa_rd_n", rd_n, 0);
    check("sa_done_n", done_n, 0);
    check("sa_Y", bus.Y_out, yfill(8'h10));

    // Reset mid-job clears the Y bank and stops the job.
    run_job(8, -1, -1, 5, 1'b0);
    check("rstjob_busy_c5", busy_log[5], 1);
    check("rstjob_busy_c6", busy_log[6], 0);
    check("rstjob_done_n", done_n, 0);
    check("rstjob_Y", bus.Y_out, 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
